// File: rtl/common.sv
// Shared cache-bus types used by the caches and memory-side responders.
// Request/response structs are flat packed vectors so they can cross module boundaries unchanged.
package common;

  typedef logic [63:0] word_t;
  typedef logic [7:0]  strobe_t;
  typedef logic [3:0]  mlen_t;
  typedef logic [2:0]  msize_t;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'b00,
    AXI_BURST_INCR  = 2'b01
  } axi_burst_type_t;

  typedef struct packed {
    logic            valid;
    logic            is_write;
    msize_t          size;
    logic [63:0]     addr;
    strobe_t         strobe;
    word_t           data;
    mlen_t           len;
    axi_burst_type_t burst;
  } cbus_req_t;

  typedef struct packed {
    logic  ready;
    logic  last;
    word_t data;
  } cbus_resp_t;

  localparam int unsigned CBUS_SRAM_DEFAULT_LATENCY = 2;

endpackage

// File: rtl/cbus_sram_array.sv
// 1R1W word SRAM with per-byte write enables; read data lands one cycle after rd_addr.
// Contents are never reset, so an aborted burst leaves already-written words in place.
module cbus_sram_array
  import common::*;
#(
  parameter int ADDR_BITS = 12
) (
  input  logic                 clk,
  input  logic                 wr_vld,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  strobe_t              wr_strb,
  input  word_t                wr_dat,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output word_t                rd_dat
);

  localparam int DEPTH = 1 << ADDR_BITS;

  word_t mem_q [DEPTH];
  word_t rd_dat_q;

  always_ff @(posedge clk) begin
    if (wr_vld) begin
      for (int b = 0; b < 8; b++) begin
        if (wr_strb[b]) mem_q[wr_addr][8*b +: 8] <= wr_dat[8*b +: 8];
      end
    end
    rd_dat_q <= mem_q[rd_addr];
  end

  assign rd_dat = rd_dat_q;

endmodule

// File: rtl/cbus_sram_responder.sv
// Cache-bus SRAM responder: LATENCY wait cycles after acceptance, then len+1 back-to-back beats, then one DONE cycle.
// No backpressure: the master must accept/supply one beat per cycle while ready=1; all cresp fields are registered.
module cbus_sram_responder
  import common::*;
#(
  parameter int ADDR_BITS = 12,
  parameter int LATENCY   = CBUS_SRAM_DEFAULT_LATENCY
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  creq,
  output cbus_resp_t cresp
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_BURST = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int WCW = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

  logic [1:0]           state_q, state_d;
  logic [WCW-1:0]       wait_q, wait_d;
  mlen_t                beat_q, beat_d;
  mlen_t                len_q, len_d;
  logic                 wr_q, wr_d;
  logic                 incr_q, incr_d;
  logic [ADDR_BITS-1:0] idx_q, idx_d;
  logic                 ready_q, ready_d;
  logic                 last_q, last_d;
  logic                 rd_vld_q, rd_vld_d;

  word_t                sram_rd_dat;
  logic                 unused_req_bits;

  // size, sub-word offset and out-of-range address bits carry no meaning here
  assign unused_req_bits = ^{creq.size, creq.addr[63:ADDR_BITS+3], creq.addr[2:0]};

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    beat_d  = beat_q;
    len_d   = len_q;
    wr_d    = wr_q;
    incr_d  = incr_q;
    idx_d   = idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (creq.valid) begin
          len_d  = creq.len;
          wr_d   = creq.is_write;
          incr_d = (creq.burst == AXI_BURST_INCR);
          idx_d  = creq.addr[ADDR_BITS+2:3];
          beat_d = '0;
          if (LATENCY == 0) begin
            state_d = S_BURST;
          end else begin
            state_d = S_WAIT;
            wait_d  = WCW'(LATENCY);
          end
        end
      end
      S_WAIT: begin
        wait_d = wait_q - 1'b1;
        if (wait_q <= 1) state_d = S_BURST;
      end
      S_BURST: begin
        if (last_q) begin
          state_d = S_DONE;
        end else begin
          beat_d = beat_q + 1'b1;
          if (incr_q) idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // idx_d doubles as the SRAM read address so data is ready on the beat itself
    ready_d  = (state_d == S_BURST);
    last_d   = ready_d && (beat_d == len_d);
    rd_vld_d = ready_d && !wr_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      wait_q   <= '0;
      beat_q   <= '0;
      len_q    <= '0;
      wr_q     <= 1'b0;
      incr_q   <= 1'b0;
      idx_q    <= '0;
      ready_q  <= 1'b0;
      last_q   <= 1'b0;
      rd_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      beat_q   <= beat_d;
      len_q    <= len_d;
      wr_q     <= wr_d;
      incr_q   <= incr_d;
      idx_q    <= idx_d;
      ready_q  <= ready_d;
      last_q   <= last_d;
      rd_vld_q <= rd_vld_d;
    end
  end

  cbus_sram_array #(
    .ADDR_BITS (ADDR_BITS)
  ) u_array (
    .clk     (clk),
    .wr_vld  (ready_q && wr_q),
    .wr_addr (idx_q),
    .wr_strb (creq.strobe),
    .wr_dat  (creq.data),
    .rd_addr (idx_d),
    .rd_dat  (sram_rd_dat)
  );

  assign cresp.ready = ready_q;
  assign cresp.last  = last_q;
  assign cresp.data  = rd_vld_q ? sram_rd_dat : '0;

endmodule

// File: tb/tb_cbus_sram_responder.sv
// Randomized scoreboard bench for cbus_sram_responder against a word-array reference model.
module tb_cbus_sram_responder;
  import common::*;

  localparam int LAT   = 2;
  localparam int AB    = 6;
  localparam int DEPTH = 1 << AB;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  cbus_req_t  creq;
  cbus_resp_t cresp;

  always #5 clk = ~clk;

  cbus_sram_responder #(
    .ADDR_BITS (AB),
    .LATENCY   (LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .creq  (creq),
    .cresp (cresp)
  );

  typedef struct {
    bit          wr;
    logic [63:0] data;
    bit          last;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [63:0] ref_mem [DEPTH];
  logic [63:0] wdat [16];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic int idx_at(input int idx0, input bit incr, input int k);
    return incr ? (idx0 + k) % DEPTH : idx0;
  endfunction

  // Monitor: every ready beat must match the head of the expectation queue
  always @(negedge clk) begin
    if (reset) begin
      if (cresp.ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_beat: got ready=1 expected no beat (cycle %0d)", cyc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("beat_cycle", 64'(cyc), 64'(mon_e.cyc));
          chk("beat_last", 64'(cresp.last), 64'(mon_e.last));
          if (!mon_e.wr) chk("read_data", cresp.data, mon_e.data);
        end
      end else begin
        chk("idle_last", 64'(cresp.last), 64'd0);
      end
    end
  end

  task automatic do_req(input bit wr, input bit incr, input int len, input logic [63:0] addr,
                        input strobe_t strb, input int abort_at, input bit done_valid);
    int   idx0, acc, k, wait_n, ii;
    exp_t e;
    idx0 = int'((addr >> 3) % DEPTH);
    @(negedge clk);
    creq.valid    = 1'b1;
    creq.is_write = wr;
    creq.burst    = incr ? AXI_BURST_INCR : AXI_BURST_FIXED;
    creq.len      = mlen_t'(len);
    creq.addr     = addr;
    creq.strobe   = strb;
    creq.data     = wdat[0];
    creq.size     = 3'($urandom);
    @(posedge clk);
    #1;
    acc = cyc;
    // scramble the request fields that must have been latched at acceptance
    creq.valid    = 1'b0;
    creq.addr     = {$urandom, $urandom};
    creq.len      = mlen_t'($urandom);
    creq.is_write = 1'($urandom);
    creq.burst    = axi_burst_type_t'($urandom_range(0, 1));
    for (int j = 0; j <= len; j++) begin
      e.wr   = wr;
      e.last = (j == len);
      e.cyc  = acc + LAT + j;
      e.data = ref_mem[idx_at(idx0, incr, j)];
      exp_q.push_back(e);
    end
    k = 0;
    wait_n = 0;
    while (k <= len) begin
      @(negedge clk);
      if (cresp.ready) begin
        if (k == abort_at) begin
          #2;
          reset = 1'b0;
          #1;
          chk("abort_ready", 64'(cresp.ready), 64'd0);
          chk("abort_last", 64'(cresp.last), 64'd0);
          chk("abort_data", cresp.data, 64'd0);
          exp_q.delete();
          repeat (2) @(negedge clk);
          creq.valid = 1'b0;
          reset = 1'b1;
          return;
        end
        @(posedge clk);
        if (wr) begin
          ii = idx_at(idx0, incr, k);
          for (int b = 0; b < 8; b++)
            if (strb[b]) ref_mem[ii][8*b +: 8] = creq.data[8*b +: 8];
        end
        #1;
        k++;
        if (k <= len) creq.data = wdat[k];
      end else begin
        wait_n++;
        if (wait_n > LAT + 4) begin
          n_cmp++;
          n_bad++;
          $display("FAIL beat_timeout: got no ready for %0d cycles expected beat %0d", wait_n, k);
          exp_q.delete();
          return;
        end
      end
    end
    // DONE cycle: a valid raised here must not start a new request
    if (done_valid) creq.valid = 1'b1;
    @(posedge clk);
    #1;
    creq.valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 64'd0;
    creq          = '0;
    creq.valid    = 1'b1;
    creq.is_write = 1'b1;
    creq.strobe   = 8'hFF;
    creq.data     = 64'hDEAD_BEEF_0000_0001;
    reset         = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("reset_ready", 64'(cresp.ready), 64'd0);
      chk("reset_last", 64'(cresp.last), 64'd0);
      chk("reset_data", cresp.data, 64'd0);
    end
    creq.valid = 1'b0;
    reset = 1'b1;

    // preload word i with value i
    for (int blk = 0; blk < DEPTH / 16; blk++) begin
      for (int i = 0; i < 16; i++) wdat[i] = 64'(blk * 16 + i);
      do_req(1'b1, 1'b1, 15, 64'(blk * 128), 8'hFF, -1, 1'b0);
    end

    wdat[0] = 64'h1122_3344_5566_7788;
    do_req(1'b1, 1'b1, 0, 64'h40, 8'hFF, -1, 1'b0);
    do_req(1'b0, 1'b1, 0, 64'h40, 8'h00, -1, 1'b0);
    wdat[0] = 64'hAAAA_AAAA_BBBB_BBBB;
    do_req(1'b1, 1'b1, 0, 64'h40, 8'h0F, -1, 1'b0);
    do_req(1'b0, 1'b1, 0, 64'h40, 8'h00, -1, 1'b0);
    do_req(1'b0, 1'b1, 15, 64'h80, 8'h00, -1, 1'b0);

    for (int i = 0; i < 4; i++) wdat[i] = 64'(i + 1);
    do_req(1'b1, 1'b0, 3, 64'h100, 8'hFF, -1, 1'b0);
    do_req(1'b0, 1'b1, 0, 64'h100, 8'h00, -1, 1'b0);
    do_req(1'b0, 1'b1, 1, 64'((DEPTH - 1) * 8), 8'h00, -1, 1'b0);

    for (int i = 0; i < 8; i++) wdat[i] = {$urandom, $urandom};
    do_req(1'b1, 1'b1, 7, 64'h0, 8'hFF, 3, 1'b0);
    do_req(1'b0, 1'b1, 7, 64'h0, 8'h00, -1, 1'b0);

    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < 16; i++) wdat[i] = {$urandom, $urandom};
      do_req(1'($urandom), 1'($urandom), $urandom_range(0, 15), {$urandom, $urandom},
             strobe_t'($urandom), -1, $urandom_range(0, 3) == 0);
    end
    do_req(1'b0, 1'b1, 15, 64'h0, 8'h00, -1, 1'b0);

    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cbus_sram_responder.md
# cbus_sram_responder

Memory-side responder for the cache bus: accepts `cbus_req_t` requests issued by the instruction/data caches and answers with `cbus_resp_t` beats from an internal word-addressed SRAM. Supports single and burst reads/writes with byte strobes and a programmable initial latency. It serves as the memory model behind the cache in simulation, and as an on-chip scratch memory.

## Interface
- `ADDR_BITS`, 12: log2 of SRAM depth in 64-bit words.
- `LATENCY`, 2: wait cycles between request acceptance and first beat; 0 is legal.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low (0 = reset asserted), released synchronously by the environment.
- `creq`  in  `cbus_req_t`  request: `valid`, `is_write`, `size`, `addr` (64), `strobe` (8), `data` (64), `len` (4, beats−1), `burst` (FIXED/INCR).
- `cresp`  out  `cbus_resp_t`  response: `ready`, `last`, `data` (64).

## Operation
- States: IDLE, WAIT, BURST, DONE.
- IDLE: `ready=0`. On `creq.valid=1` at a rising edge, latch `addr`, `len`, `is_write`, and `burst`. Clear the beat counter. Go to WAIT with wait counter=`LATENCY`, or to BURST directly if `LATENCY==0`.
- WAIT: decrement the wait counter each cycle. Go to BURST when it reaches 1, so exactly `LATENCY` cycles elapse.
- BURST: one beat per cycle with `ready=1`.
  - Read: `cresp.data` = SRAM word at the current index.
  - Write: at the edge where `ready=1`, the byte lanes selected by `creq.strobe` are written from `creq.data`. Unselected bytes are unchanged.
  - `last=1` only on the beat where beat counter == latched `len`; after that beat, go to DONE.
- DONE: one cycle with `ready=0`, `last=0`, during which the master drops `valid`. Then go to IDLE. A `valid` still high in DONE is ignored.
- Word index is `addr[ADDR_BITS+2:3]`. Address bits above the SRAM range are ignored, so out-of-range accesses wrap modulo depth. Bits [2:0] are ignored; byte selection comes only from `strobe`.
- INCR: index increments by 1 per beat, wrapping from depth−1 to 0. FIXED: index is constant for all beats.
- `size` is accepted but unused, because `strobe` fully defines byte lanes.
- Request fields other than `data` and `strobe` are sampled only in IDLE. Changes to them mid-burst are ignored.
- Reset (asynchronous, `reset=0`):
  - Go to IDLE and force `ready=0`, `last=0`, `data=0` immediately.
  - An in-flight burst is aborted. Beats already written stay in SRAM, and no further beats are written.
  - SRAM contents are not cleared. The simulation initial value is all zeros.

## Timing
- Request sampled at edge t0. The first beat has `ready=1` in cycle t0+1+`LATENCY`; with `LATENCY=0`, that is the cycle right after acceptance.
- A burst of `len+1` beats occupies consecutive cycles, with no bubbles.
- Minimum request-to-request spacing: `LATENCY` + beats + 2 cycles (acceptance cycle plus DONE).
- All outputs are registered; no combinational path from `creq` to `cresp`.
- Read data is valid in the same cycle as `ready`. A read of a word written by an earlier completed request returns the new value.

## Structure
- `cbus_req_t`, `cbus_resp_t`, `mlen_t`, `axi_burst_type_t`, `strobe_t`, and `word_t` already live in `common`. Add `CBUS_SRAM_DEFAULT_LATENCY` there.
- The state enum is local to the module.
- One sub-module, `cbus_sram_array`:
  - synchronous 1R1W word array, `2^ADDR_BITS` × 64;
  - per-byte write enable;
  - read port registered, so reads are issued one cycle ahead of the beat. The responder computes the next index combinationally from the current state.

## Test plan
- Reset behaviour: assert `reset=0` for 3 cycles with `creq.valid=1` → `ready`, `last`, and `data` stay 0 throughout. After release, the block starts in IDLE.
- Single write then read, `LATENCY=2`:
  - Write `addr=0x40`, `strobe=0xFF`, `data=0x1122334455667788`, `len=0` → `ready` and `last` high in cycle t0+3.
  - Then a read of `0x40` returns `0x1122334455667788` with `last=1`.
- Strobed write: write `0x40` with `strobe=0x0F`, `data=0xAAAAAAAABBBBBBBB` → a later read returns `0x11223344BBBBBBBB`.
- INCR burst read, `len=15`, from `addr=0x80` after preloading word i with i → 16 consecutive `ready` beats with data 0x10..0x1F, and `last` only on the 16th.
- FIXED and wrap cases:
  - FIXED write burst, `len=3`, to `0x100`, data 1,2,3,4 → a read of `0x100` returns 4.
  - INCR read starting at word depth−1, `len=1` → returns word depth−1, then word 0.
- Reset mid-burst: assert reset on beat 3 of an 8-beat INCR write → words 0–2 are updated and words 3–7 are unchanged. The next request completes normally.
